// File: rtl/core_pkg.sv
// Shared core definitions for the load/store path: funct3 encodings, LSU FSM
// states, the request bundle and the fault decode.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LDX,
        S_WR,
        S_ERR
    } lsu_state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_op_t;

    // Illegal funct3 for the direction, misaligned half/word, or word index past memory.
    function automatic logic op_fault(input lsu_op_t op, input int unsigned mem_words);
        logic illegal;
        logic misal;
        logic oor;
        if (op.we)
            illegal = !(op.funct3 inside {F3_B, F3_H, F3_W});
        else
            illegal = !(op.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misal = ((op.funct3 == F3_H || op.funct3 == F3_HU) && op.addr[0]) ||
                (op.funct3 == F3_W && op.addr[1:0] != 2'b00);
        oor   = {2'b00, op.addr[31:2]} >= 32'(mem_words);
        return illegal | misal | oor;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between the execute stage (master) and the LSU (slave).
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
    import core_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = word[{lane, 3'b000} +: 8];
        half_v  = lane[1] ? word[31:16] : word[15:0];
        ld_data = word;
        case (funct3)
            F3_B:    ld_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   ld_data = {24'h0, byte_v};
            F3_H:    ld_data = {{16{half_v[15]}}, half_v};
            F3_HU:   ld_data = {16'h0, half_v};
            default: ld_data = word;
        endcase
    end

    always_comb begin
        st_word = word;
        case (funct3)
            F3_B: st_word[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) st_word[31:16] = wdata[15:0];
                else         st_word[15:0]  = wdata[15:0];
            end
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one RV32I load/store, drives a single-port word memory
// with registered read, and does sub-word stores as read-modify-write.
module lsu
    import core_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_if.slave        bus,
    output logic [31:0] mem_addr,
    output logic        mem_r_enable,
    output logic        mem_w_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state, state_nxt;
    lsu_op_t     req_op;
    logic        accept;
    logic        op_we;
    logic [2:0]  op_f3;
    logic [1:0]  op_lane;
    logic [31:0] op_wdata;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    assign req_op = '{we: bus.req_we, funct3: bus.req_funct3,
                      addr: bus.req_addr, wdata: bus.req_wdata};
    assign bus.req_ready = (state == S_IDLE);
    assign accept        = bus.req_valid && (state == S_IDLE);

    lsu_align u_align (
        .lane    (op_lane),
        .funct3  (op_f3),
        .word    (mem_rdata),
        .wdata   (op_wdata),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        mem_r_enable = 1'b0;
        mem_w_enable = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (op_fault(req_op, MEM_WORDS))  state_nxt = S_ERR;
                    else if (req_op.we && req_op.funct3 == F3_W) state_nxt = S_WR;
                    else                              state_nxt = S_RD;
                end
            end
            S_RD: begin
                mem_r_enable = 1'b1;
                state_nxt    = op_we ? S_WR : S_LDX;
            end
            S_LDX: state_nxt = S_IDLE;
            S_WR: begin
                mem_w_enable = 1'b1;
                state_nxt    = S_IDLE;
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sub-word stores merge into the word read back in RD; memory holds it through WR.
    assign mem_wdata = (state == S_WR && op_f3 != F3_W) ? st_word : op_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_we          <= 1'b0;
            op_f3          <= 3'b000;
            op_lane        <= 2'b00;
            op_wdata       <= 32'h0;
            mem_addr       <= 32'h0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'h0;
        end else begin
            bus.resp_valid <= (state == S_LDX) || (state == S_WR) || (state == S_ERR);
            bus.resp_err   <= (state == S_ERR);
            if (accept) begin
                op_we    <= req_op.we;
                op_f3    <= req_op.funct3;
                op_lane  <= req_op.addr[1:0];
                op_wdata <= req_op.wdata;
                mem_addr <= {req_op.addr[31:2], 2'b00};
            end
            case (state)
                S_LDX:       bus.resp_rdata <= ld_data;
                S_WR, S_ERR: bus.resp_rdata <= 32'h0;
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a behavioural registered-read word memory.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [0:255];

    int pass_cnt  = 0;
    int total_cnt = 0;

    lsu_if bus ();

    lsu #(.MEM_WORDS(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .mem_addr     (mem_addr),
        .mem_r_enable (mem_r_enable),
        .mem_w_enable (mem_w_enable),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_w_enable) mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_r_enable) mem_rdata <= mem[mem_addr[9:2]];
    end

    // Issue one request from an IDLE cycle; returns response cycle (accept cycle = 0).
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                         output logic err, output int nrd, output int nwr,
                         output logic [31:0] maddr);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; rdata = 'x; err = 'x;
        maddr = mem_addr;
        for (int k = 1; k <= 10; k++) begin
            if (bus.resp_valid) begin
                lat = k; rdata = bus.resp_rdata; err = bus.resp_err;
                break;
            end
            nrd += int'(mem_r_enable);
            nwr += int'(mem_w_enable);
            @(posedge clk); #1;
        end
        if (lat == 0) begin
            total_cnt++;
            $display("FAIL op_timeout addr=%h got no resp_valid within 10 cycles", addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (mem_r_enable !== 1'b0 || mem_w_enable !== 1'b0)
            $display("FAIL rst_strobes got r=%b w=%b want 0 0", mem_r_enable, mem_w_enable); else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", bus.req_ready); else pass_cnt++;
        total_cnt++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0)
            $display("FAIL rst_resp got v=%b e=%b want 0 0", bus.resp_valid, bus.resp_err); else pass_cnt++;
        total_cnt++; if (bus.resp_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", bus.resp_rdata); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
            $display("FAIL rst_mem got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); else pass_cnt++;
    endtask

    task automatic test_sw_lw();
        int lat, nrd, nwr; logic [31:0] rd, ma; logic err;
        do_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, err, nrd, nwr, ma);
        total_cnt++; if (lat !== 2) $display("FAIL sw_lat got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (rd !== 32'h0 || err !== 1'b0) $display("FAIL sw_resp got rd=%h err=%b want 0 0", rd, err); else pass_cnt++;
        total_cnt++; if (nrd !== 0 || nwr !== 1) $display("FAIL sw_strobes got r=%0d w=%0d want 0 1", nrd, nwr); else pass_cnt++;
        total_cnt++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL sw_mem got %h want deadbeef", mem[4]); else pass_cnt++;
        do_op(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, err, nrd, nwr, ma);
        total_cnt++; if (lat !== 3) $display("FAIL lw_lat got %0d want 3", lat); else pass_cnt++;
        total_cnt++; if (rd !== 32'hDEADBEEF || err !== 1'b0) $display("FAIL lw_resp got rd=%h err=%b want deadbeef 0", rd, err); else pass_cnt++;
        total_cnt++; if (nrd !== 1 || nwr !== 0) $display("FAIL lw_strobes got r=%0d w=%0d want 1 0", nrd, nwr); else pass_cnt++;
    endtask

    task automatic test_load_ext();
        int lat, nrd, nwr; logic [31:0] rd, ma; logic err;
        logic [2:0]  f3 [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad [4]  = '{32'h23, 32'h23, 32'h22, 32'h20};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        do_op(1'b1, 3'b010, 32'h20, 32'h80FF7F01, lat, rd, err, nrd, nwr, ma);
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, f3[i], ad[i], 32'h0, lat, rd, err, nrd, nwr, ma);
            total_cnt++; if (rd !== exp[i] || err !== 1'b0)
                $display("FAIL ld_ext%0d got rd=%h err=%b want %h 0", i, rd, err, exp[i]); else pass_cnt++;
            total_cnt++; if (ma !== 32'h20 || lat !== 3)
                $display("FAIL ld_addr%0d got addr=%h lat=%0d want 00000020 3", i, ma, lat); else pass_cnt++;
        end
    endtask

    task automatic test_rmw();
        int lat, nrd, nwr; logic [31:0] rd, ma; logic err;
        do_op(1'b1, 3'b010, 32'h30, 32'h11223344, lat, rd, err, nrd, nwr, ma);
        do_op(1'b1, 3'b000, 32'h31, 32'h000000AA, lat, rd, err, nrd, nwr, ma);
        total_cnt++; if (mem[12] !== 32'h1122AA44) $display("FAIL sb_mem got %h want 1122aa44", mem[12]); else pass_cnt++;
        total_cnt++; if (nrd !== 1 || nwr !== 1 || lat !== 3 || err !== 1'b0)
            $display("FAIL sb_seq got r=%0d w=%0d lat=%0d err=%b want 1 1 3 0", nrd, nwr, lat, err); else pass_cnt++;
        do_op(1'b1, 3'b001, 32'h32, 32'h1234BEEF, lat, rd, err, nrd, nwr, ma);
        total_cnt++; if (mem[12] !== 32'hBEEFAA44) $display("FAIL sh_mem got %h want beefaa44", mem[12]); else pass_cnt++;
        total_cnt++; if (nrd !== 1 || nwr !== 1 || lat !== 3 || rd !== 32'h0)
            $display("FAIL sh_seq got r=%0d w=%0d lat=%0d rd=%h want 1 1 3 0", nrd, nwr, lat, rd); else pass_cnt++;
    endtask

    task automatic test_faults();
        int lat, nrd, nwr; logic [31:0] rd, ma; logic err;
        logic        we [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3 [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100};
        logic [31:0] ad [5] = '{32'h12, 32'h33, 32'h30, 32'h400, 32'h30};
        for (int i = 0; i < 5; i++) begin
            do_op(we[i], f3[i], ad[i], 32'h5555_5555, lat, rd, err, nrd, nwr, ma);
            total_cnt++; if (err !== 1'b1 || rd !== 32'h0 || lat !== 2)
                $display("FAIL fault%0d got err=%b rd=%h lat=%0d want 1 0 2", i, err, rd, lat); else pass_cnt++;
            total_cnt++; if (nrd !== 0 || nwr !== 0)
                $display("FAIL fault%0d_strobes got r=%0d w=%0d want 0 0", i, nrd, nwr); else pass_cnt++;
        end
        total_cnt++; if (mem[12] !== 32'hBEEFAA44) $display("FAIL fault_mem got %h want beefaa44", mem[12]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bus.req_we = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h44; bus.req_wdata = 32'hCAFEF00D;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h44; bus.req_wdata = 32'h0;
        total_cnt++; if (bus.resp_valid !== 1'b0 || mem_w_enable !== 1'b1)
            $display("FAIL b2b_c1 got v=%b w=%b want 0 1", bus.resp_valid, mem_w_enable); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b1)
            $display("FAIL b2b_c2 got v=%b ready=%b want 1 1", bus.resp_valid, bus.req_ready); else pass_cnt++;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        total_cnt++; if (bus.req_ready !== 1'b0 || mem_r_enable !== 1'b1)
            $display("FAIL b2b_accept got ready=%b r=%b want 0 1", bus.req_ready, mem_r_enable); else pass_cnt++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hCAFEF00D)
            $display("FAIL b2b_lw got v=%b rd=%h want 1 cafef00d", bus.resp_valid, bus.resp_rdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int lat, nrd, nwr; logic [31:0] rd, ma; logic err;
        int seen = 0;
        bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h30; bus.req_wdata = 32'h77;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (mem_w_enable !== 1'b1) $display("FAIL rmid_wr got w=%b want 1", mem_w_enable); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (mem_w_enable !== 1'b0 || mem_r_enable !== 1'b0)
            $display("FAIL rmid_strobes got r=%b w=%b want 0 0", mem_r_enable, mem_w_enable); else pass_cnt++;
        repeat (2) begin
            @(posedge clk); #1;
            seen += int'(bus.resp_valid);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            seen += int'(bus.resp_valid);
        end
        total_cnt++; if (seen !== 0) $display("FAIL rmid_resp got %0d resp_valid cycles want 0", seen); else pass_cnt++;
        do_op(1'b0, 3'b010, 32'h30, 32'h0, lat, rd, err, nrd, nwr, ma);
        total_cnt++; if (rd !== 32'hBEEFAA44 || mem[12] !== 32'hBEEFAA44)
            $display("FAIL rmid_mem got rd=%h mem=%h want beefaa44", rd, mem[12]); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        test_reset();
        test_sw_lw();
        test_load_ext();
        test_rmw();
        test_faults();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
